// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating multiplexer with a single registered,
// valid/ready-handshaked output stage. The grant is round-robin
// (mode_i=0) or fixed priority with the lowest index winning (mode_i=1).
// Optional feature macro: RR_ARB_MUX_STALL_CNT_EN. It adds the stall_cnt_o
// output, a saturating count of cycles spent in valid_o && !ready_i.
module rr_arb_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          mode_i,
    input  logic [NUM_CH-1:0]             valid_i,
    input  logic [NUM_CH*DATA_W-1:0]      data_i,
    output logic [NUM_CH-1:0]             ready_o,
    output logic                          valid_o,
    output logic [DATA_W-1:0]             data_o,
    output logic [$clog2(NUM_CH)-1:0]     ch_o,
    input  logic                          ready_i
`ifdef RR_ARB_MUX_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic                 valid_reg;
    logic [DATA_W-1:0]    data_reg;
    logic [IDX_W-1:0]     ch_reg;
    logic [IDX_W-1:0]     ptr_reg;

    logic                 free;
    logic                 load;
    logic [IDX_W-1:0]     grant_rr;
    logic [IDX_W-1:0]     grant_fp;
    logic [IDX_W-1:0]     grant;
    logic [DATA_W-1:0]    ch_data [NUM_CH];

    // Split the flattened input bus into per-channel words
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_data[gi] = data_i[gi*DATA_W +: DATA_W];
    end

    // The output register can take a new word when empty or being drained
    assign free = !valid_reg || ready_i;
    assign load = free && (|valid_i);

    // Round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        int  sum;
        logic found;
        grant_rr = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = int'(ptr_reg) + i;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            if (!found && valid_i[sum]) begin
                found    = 1'b1;
                grant_rr = IDX_W'(sum);
            end
        end
    end

    // Fixed priority: scanning downwards leaves the lowest requester last
    always_comb begin
        grant_fp = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                grant_fp = IDX_W'(i);
            end
        end
    end

    assign grant = mode_i ? grant_fp : grant_rr;

    // One-hot accept for the granted channel, only when a load happens
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
        assign ready_o[gi] = load && (grant == IDX_W'(gi));
    end

    // Output stage and round-robin pointer; the pointer moves only on a load
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ch_reg    <= '0;
            ptr_reg   <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= ch_data[grant];
            ch_reg    <= grant;
            if (!mode_i) begin
                ptr_reg <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);
            end
        end else if (free) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;
    assign ch_o    = ch_reg;

`ifdef RR_ARB_MUX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of downstream-stalled cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
        end else if (valid_reg && !ready_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux (NUM_CH=4, DATA_W=32). Directed and randomized
// steps are checked against a transaction-level reference model.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [N-1:0]     valid_in;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     ready_out;
    logic             valid_out;
    logic [W-1:0]     data_out;
    logic [1:0]       ch_out;
    logic             ready_in;
`ifdef RR_ARB_MUX_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    rr_arb_mux #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .mode_i  (mode),
        .valid_i (valid_in),
        .data_i  (data_in),
        .ready_o (ready_out),
        .valid_o (valid_out),
        .data_o  (data_out),
        .ch_o    (ch_out),
        .ready_i (ready_in)
`ifdef RR_ARB_MUX_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] words [N];
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    longint       m_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        m_stall = 0;
    endfunction

    // Returns the granted channel, or -1 if nobody requests
    function automatic int model_grant(input bit m, input logic [N-1:0] v);
        if (v == '0) return -1;
        if (m) begin
            for (int k = 0; k < N; k++) if (v[k]) return k;
        end
        for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic void pack_words();
        for (int k = 0; k < N; k++) data_in[k*W +: W] = words[k];
    endfunction

    // One clock cycle: drive, check combinational accept, clock, check outputs
    task automatic cycle(input bit m, input logic [N-1:0] v, input bit r, input string tag);
        int g;
        bit free;
        logic [N-1:0] exp_ready;
        mode = m; valid_in = v; ready_in = r;
        pack_words();
        #1;
        free = !m_valid || r;
        g = free ? model_grant(m, v) : -1;
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check({tag, ".ready_o"}, 64'(ready_out), 64'(exp_ready));
        @(posedge clk);
        if (m_valid && !r && m_stall != 64'hFFFF_FFFF) m_stall++;
        if (g >= 0) begin
            m_valid = 1;
            m_data  = words[g];
            m_ch    = g;
            if (!m) m_ptr = (g + 1) % N;
        end else if (free) begin
            m_valid = 0;
        end
        #1;
        $display("step %s mode=%0d valid_i=%b ready_i=%0d -> valid_o=%0d ch_o=%0d data_o=%h",
                 tag, m, v, r, valid_out, ch_out, data_out);
        check({tag, ".valid_o"}, 64'(valid_out), 64'(m_valid));
        check({tag, ".data_o"},  64'(data_out),  64'(m_data));
        check({tag, ".ch_o"},    64'(ch_out),    64'(m_ch));
`ifdef RR_ARB_MUX_STALL_CNT_EN
        check({tag, ".stall_cnt_o"}, 64'(stall_cnt), 64'(m_stall));
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; valid_in = '0; ready_in = 1'b0;
        for (int k = 0; k < N; k++) words[k] = '0;
        pack_words();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.valid_o", 64'(valid_out), 64'd0);
        check("reset.data_o",  64'(data_out),  64'd0);
        check("reset.ch_o",    64'(ch_out),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle: nothing requested for 5 cycles
        for (int i = 0; i < 5; i++) cycle(0, 4'b0000, 1, "idle");

        // Round-robin fairness with all channels requesting
        for (int k = 0; k < N; k++) words[k] = 32'h1000_0000 + k;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 4'b1111, 1, "rr_fair");
            check("rr_fair.seq", 64'(ch_out), 64'(i % 4));
        end

        // Fixed priority: channel 1 beats channel 3 every time
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'b1010, 1, "fixed");
            check("fixed.ch", 64'(ch_out), 64'd1);
        end

        // Backpressure: hold channel 2's word while downstream stalls
        cycle(1, 4'b0100, 1, "bp_load");
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) words[k] = $urandom;
            cycle(0, 4'b1111, 0, "bp_stall");
            check("bp_stall.ch", 64'(ch_out), 64'd2);
            check("bp_stall.data", 64'(data_out), 64'h1000_0002);
        end
`ifdef RR_ARB_MUX_STALL_CNT_EN
        check("bp_stall.count4", 64'(stall_cnt), 64'd4);
`endif

        // Pointer wrap/skip: grant 2 sets pointer to 3, then 0, then 2
        cycle(0, 4'b0100, 1, "wrap_set");
        cycle(0, 4'b0101, 1, "wrap_a");
        check("wrap_a.ch", 64'(ch_out), 64'd0);
        cycle(0, 4'b0101, 1, "wrap_b");
        check("wrap_b.ch", 64'(ch_out), 64'd2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) words[k] = $urandom;
            cycle(bit'($urandom_range(0, 3) == 0), N'($urandom), bit'($urandom_range(0, 3) != 0), "rand");
        end

        // Async reset mid-stream, asserted between clock edges
        for (int k = 0; k < N; k++) words[k] = 32'hA000_0000 + k;
        cycle(0, 4'b1111, 1, "pre_rst");
        cycle(0, 4'b1111, 1, "pre_rst");
        check("pre_rst.valid", 64'(valid_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid_o", 64'(valid_out), 64'd0);
        check("async_rst.ch_o",    64'(ch_out),    64'd0);
        check("async_rst.data_o",  64'(data_out),  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 4'b1111, 1, "post_rst");
        check("post_rst.ch", 64'(ch_out), 64'd0);
        cycle(0, 4'b1111, 1, "post_rst");
        check("post_rst.ch2", 64'(ch_out), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer. Generalises the fixed 4:1 combinational select into a registered, handshaked channel merger.
- Each input channel presents data with valid/ready. The block picks one requesting channel per transfer, round-robin or fixed-priority by mode, and drives it through a single output register stage.
- Used wherever several producers share one datapath consumer, e.g. memory-port sharing between fetch and load/store in the multicycle core.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- DATA_W, XLEN, width of each data word.
- IDX_W, $clog2(NUM_CH), width of the channel index. Derived; not for override.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- mode_i  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- valid_i  input  NUM_CH  per-channel request valid.
- data_i  input  NUM_CH*DATA_W  flattened channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- ready_o  output  NUM_CH  per-channel accept; one-hot or zero.
- valid_o  output  1  output register holds a valid word.
- data_o  output  DATA_W  registered selected data.
- ch_o  output  IDX_W  index of the channel that supplied data_o.
- ready_i  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): valid_o=0, data_o=0, ch_o=0, round-robin pointer=0.
- ready_o is combinational and depends on valid_i, mode_i, the pointer, valid_o and ready_i.
- Output register "free" condition: free = !valid_o || ready_i.
- Load rule: when free and at least one valid_i bit is set:
  - exactly one ready_o bit is asserted, for the granted channel g;
  - next edge: data_o <= data_i[g], ch_o <= g, valid_o <= 1.
- When not free, or no requests, ready_o = 0.
- Drain: if free and no requests, valid_o <= 0 next edge; data_o and ch_o hold their values.
- Full throughput: one transfer per cycle when ready_i is held high. Latency from input accept to valid_o is 1 cycle.
- Downstream stall: while valid_o && !ready_i, data_o and ch_o are stable.
- Grant, round-robin (mode_i=0):
  - search starts at pointer p and proceeds p, p+1, ..., wrapping modulo NUM_CH; g is the first requesting channel found.
  - on a load, p <= (g+1) mod NUM_CH. Wrap covers NUM_CH-1 -> 0.
- Grant, fixed priority (mode_i=1):
  - g is the lowest-index requesting channel.
  - pointer is not updated.
- mode_i may change on any cycle and takes effect on the same cycle's grant.
- Pointer changes only on an actual load; a withdrawn request causes no pointer change.
- Input protocol: inputs need not hold valid_i until ready. The block tolerates dropped requests without error.
- Reset asserted mid-transfer: output word discarded, valid_o drops immediately, pointer returns to 0.
- Non-power-of-two NUM_CH: unused index codes are never produced on ch_o.

Optional Feature:
- Macro: RR_ARB_MUX_STALL_CNT_EN.
- When defined, adds output stall_cnt_o [31:0]:
  - counts cycles with valid_o && !ready_i;
  - saturates at 32'hFFFF_FFFF;
  - reset value 0;
  - cleared only by reset.
- When undefined, the port and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, then idle: valid_i=0 for 5 cycles -> valid_o=0, ready_o=0, data_o=0 throughout.
- RR fairness: NUM_CH=4, mode_i=0, all valid_i=4'b1111, data_i[k]=32'h1000_0000+k, ready_i=1 for 8 cycles -> ch_o sequence 0,1,2,3,0,1,2,3; valid_o high from cycle 2.
- Fixed priority: mode_i=1, valid_i=4'b1010 for 3 cycles -> ch_o=1 every transfer; ready_o=4'b0010 each cycle.
- Backpressure: valid_o=1, ch_o=2, then ready_i=0 for 4 cycles with new requests pending -> ready_o=0; data_o/ch_o unchanged; with RR_ARB_MUX_STALL_CNT_EN, stall_cnt_o=4.
- Pointer wrap/skip: pointer=3, valid_i=4'b0101 -> grant 0, then next grant 2; pointer ends at 3.
- Async reset mid-stream: assert rst_ni low between clock edges while valid_o=1 -> valid_o=0 immediately; after release, first RR grant starts at channel 0.
